// File: rtl/pipe_adder.sv
// Pipelined ripple-carry adder: WIDTH-bit A+B+CIN split into STAGES chunks, one chunk per stage.
// Optional macro PIPE_ADDER_SUB_EN adds a per-transaction i_sub input selecting A-B.
module pipe_adder #(
    parameter int WIDTH  = 16,
    parameter int STAGES = 4
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_in_valid,
    output logic             o_in_ready,
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    input  logic             i_cin,
`ifdef PIPE_ADDER_SUB_EN
    input  logic             i_sub,
`endif
    output logic             o_out_valid,
    input  logic             i_out_ready,
    output logic [WIDTH-1:0] o_s,
    output logic             o_cout,
    output logic             o_ovf
);

    localparam int CW = WIDTH / STAGES;
    localparam int L  = STAGES - 1;

    if ((WIDTH % STAGES) != 0) begin : g_width_check
        $error("pipe_adder: WIDTH must be a multiple of STAGES");
    end

    logic             r_vld [STAGES];
    logic [WIDTH-1:0] r_a   [STAGES];
    logic [WIDTH-1:0] r_b   [STAGES];
    logic [WIDTH-1:0] r_s   [STAGES];
    logic             r_c   [STAGES];
    logic             r_ovf;

    logic             w_in_v   [STAGES];
    logic [WIDTH-1:0] w_in_a   [STAGES];
    logic [WIDTH-1:0] w_in_b   [STAGES];
    logic [WIDTH-1:0] w_in_s   [STAGES];
    logic             w_in_c   [STAGES];
    logic [WIDTH-1:0] w_sum_nx [STAGES];
    logic             w_cout   [STAGES];

    logic             w_adv;
    logic [WIDTH-1:0] w_b_eff;
    logic             w_cin_eff;
    logic             w_ovf;

    // Subtraction is folded in at the entry: A + ~B + 1, so later stages only ever add.
`ifdef PIPE_ADDER_SUB_EN
    assign w_b_eff   = i_sub ? ~i_b : i_b;
    assign w_cin_eff = i_sub ? 1'b1 : i_cin;
`else
    assign w_b_eff   = i_b;
    assign w_cin_eff = i_cin;
`endif

    // Whole pipe moves together; it holds only when a finished result is blocked.
    assign w_adv      = !r_vld[L] || i_out_ready;
    assign o_in_ready = w_adv;

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        logic [CW:0]      w_add;
        logic [WIDTH-1:0] w_sum;

        if (k == 0) begin : g_first
            assign w_in_v[k] = i_in_valid;
            assign w_in_a[k] = i_a;
            assign w_in_b[k] = w_b_eff;
            assign w_in_s[k] = '0;
            assign w_in_c[k] = w_cin_eff;
        end else begin : g_next
            assign w_in_v[k] = r_vld[k-1];
            assign w_in_a[k] = r_a[k-1];
            assign w_in_b[k] = r_b[k-1];
            assign w_in_s[k] = r_s[k-1];
            assign w_in_c[k] = r_c[k-1];
        end

        assign w_add = {1'b0, w_in_a[k][k*CW +: CW]}
                     + {1'b0, w_in_b[k][k*CW +: CW]}
                     + {{CW{1'b0}}, w_in_c[k]};

        always_comb begin
            w_sum               = w_in_s[k];
            w_sum[k*CW +: CW]   = w_add[CW-1:0];
        end

        assign w_sum_nx[k] = w_sum;
        assign w_cout[k]   = w_add[CW];
    end

    // Sum bit = a ^ b ^ carry-in, so the carry into the MSB is recovered from the MSB bits.
    assign w_ovf = w_cout[L] ^ w_sum_nx[L][WIDTH-1] ^ w_in_a[L][WIDTH-1] ^ w_in_b[L][WIDTH-1];

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int k = 0; k < STAGES; k++) begin
                r_vld[k] <= 1'b0;
                r_a[k]   <= '0;
                r_b[k]   <= '0;
                r_s[k]   <= '0;
                r_c[k]   <= 1'b0;
            end
            r_ovf <= 1'b0;
        end else if (w_adv) begin
            for (int k = 0; k < STAGES; k++) begin
                r_vld[k] <= w_in_v[k];
                if (w_in_v[k]) begin
                    r_a[k] <= w_in_a[k];
                    r_b[k] <= w_in_b[k];
                    r_s[k] <= w_sum_nx[k];
                    r_c[k] <= w_cout[k];
                end
            end
            if (w_in_v[L]) begin
                r_ovf <= w_ovf;
            end
        end
    end

    assign o_out_valid = r_vld[L];
    assign o_s         = r_s[L];
    assign o_cout      = r_c[L];
    assign o_ovf       = r_ovf;

endmodule
